// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the stall/flush controller.
// HAZARD_PERF_CNT_EN adds the stall_cycles / div_ops counter outputs.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_is_div;
    logic        branch_taken;
    logic        div_done;
    logic        stall_pipeline;
    logic        bubble_de;
    logic        flush_fd;
    logic        flush_de;
    logic        div_start;
    logic        div_result_valid;
    logic        div_error;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] div_ops;
`endif

    modport master (
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, div_ops,
`endif
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_is_div,
        output branch_taken, div_done,
        input  stall_pipeline, bubble_de, flush_fd, flush_de, div_start, div_result_valid,
        input  div_error
    );

    modport slave (
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, div_ops,
`endif
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_is_div,
        input  branch_taken, div_done,
        output stall_pipeline, bubble_de, flush_fd, flush_de, div_start, div_result_valid,
        output div_error
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use detection, divider sequencing with watchdog, branch flush.
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and divide-count performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_LATENCY = 8,
    parameter int unsigned DIV_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);

    if (DIV_TIMEOUT <= DIV_LATENCY || DIV_TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
        $error("pipeline_hazard_ctrl: DIV_TIMEOUT must exceed DIV_LATENCY and fit in CNT_W");
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic div_start_c;
    logic div_stall_c;
    logic div_valid_c;
    logic hazard_c;
    logic branch_c;
    logic stall_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        div_start_c = 1'b0;
        div_stall_c = 1'b0;
        div_valid_c = 1'b0;
        case (state_q)
            StIdle: begin
                if (hz.ex_is_div) begin
                    div_start_c = 1'b1;
                    div_stall_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                div_stall_c = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (hz.div_done) begin
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                    // Watchdog only flags; the FSM keeps waiting for div_done.
                    err_d = 1'b1;
                end
            end
            StDone: begin
                // ex_is_div is still high here; the same divide must not relaunch.
                div_valid_c = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign hazard_c = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // A divide in EX (or still sequencing) owns the stage, so a coincident branch is ignored.
    assign branch_c = hz.branch_taken && !hz.ex_is_div && (state_q == StIdle);
    assign stall_c  = div_stall_c || (hazard_c && !branch_c);

    assign hz.stall_pipeline   = rst && stall_c;
    assign hz.bubble_de        = rst && hazard_c && !branch_c;
    assign hz.flush_fd         = rst && branch_c;
    assign hz.flush_de         = rst && branch_c;
    assign hz.div_start        = rst && div_start_c;
    assign hz.div_result_valid = rst && div_valid_c;
    assign hz.div_error        = rst && err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] div_ops_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            div_ops_q      <= '0;
        end else begin
            if (stall_c) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (div_start_c) begin
                div_ops_q <= div_ops_q + 16'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.div_ops      = div_ops_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed divider/reset
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .DIV_LATENCY(8),
        .DIV_TIMEOUT(16),
        .CNT_W      (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       ld;
        logic       br;
        logic [3:0] exp;  // {stall, bubble, flush_fd, flush_de}
    } vec_t;

    vec_t vecs[9];

    // Reference model state (phase 0 idle, 1 waiting for divider, 2 result cycle)
    int          m_phase;
    int          m_age;
    bit          m_err;
    logic [31:0] m_stall_cycles;
    logic [15:0] m_div_ops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {hz.stall_pipeline, hz.bubble_de, hz.flush_fd, hz.flush_de,
                hz.div_start, hz.div_result_valid, hz.div_error};
    endfunction

    task automatic idle_inputs();
        hz.id_rs1       = '0;
        hz.id_rs2       = '0;
        hz.id_uses_rs1  = 1'b0;
        hz.id_uses_rs2  = 1'b0;
        hz.ex_rd        = '0;
        hz.ex_is_load   = 1'b0;
        hz.ex_is_div    = 1'b0;
        hz.branch_taken = 1'b0;
        hz.div_done     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst            = 1'b1;
        m_phase        = 0;
        m_age          = 0;
        m_err          = 1'b0;
        m_stall_cycles = '0;
        m_div_ops      = '0;
    endtask

    initial begin
        int start_cnt;
        int first_start;
        int second_start;
        bit want_div;
        int lat;
        int since;
        bit hz_m;
        bit br_m;
        bit exp_start;
        bit exp_stall;
        bit exp_bub;
        bit exp_rv;

        vecs[0] = '{5'd5,  5'd0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 4'b1100};
        vecs[1] = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[2] = '{5'd1,  5'd5, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[3] = '{5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[4] = '{5'd5,  5'd0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{5'd3,  5'd7, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 4'b1100};
        vecs[6] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[7] = '{5'd5,  5'd0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 4'b0011};
        vecs[8] = '{5'd31, 5'd1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100};

        // Outputs held at 0 during reset even with hostile inputs
        rst             = 1'b0;
        hz.id_rs1       = 5'd5;
        hz.id_rs2       = 5'd5;
        hz.id_uses_rs1  = 1'b1;
        hz.id_uses_rs2  = 1'b1;
        hz.ex_rd        = 5'd5;
        hz.ex_is_load   = 1'b1;
        hz.ex_is_div    = 1'b1;
        hz.branch_taken = 1'b1;
        hz.div_done     = 1'b1;
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        do_reset();

        // Combinational load-use / branch table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idle_inputs();
            hz.id_rs1       = vecs[i].rs1;
            hz.id_rs2       = vecs[i].rs2;
            hz.ex_rd        = vecs[i].rd;
            hz.id_uses_rs1  = vecs[i].u1;
            hz.id_uses_rs2  = vecs[i].u2;
            hz.ex_is_load   = vecs[i].ld;
            hz.branch_taken = vecs[i].br;
            #1;
            check($sformatf("vec%0d", i),
                  32'({hz.stall_pipeline, hz.bubble_de, hz.flush_fd, hz.flush_de}),
                  32'(vecs[i].exp));
        end

        // Back-to-back divides: done 8 cycles after each start, ex_is_div held through both
        start_cnt    = 0;
        first_start  = -1;
        second_start = -1;
        for (int w = 0; w < 22; w++) begin
            @(negedge clk);
            idle_inputs();
            hz.ex_is_div = (w < 20);
            hz.div_done  = (w == 8) || (w == 18);
            #1;
            check($sformatf("b2b_w%0d", w),
                  32'({hz.div_start, hz.stall_pipeline, hz.div_result_valid}),
                  32'({(w == 0) || (w == 10),
                       (w <= 8) || (w >= 10 && w <= 18),
                       (w == 9) || (w == 19)}));
            if (hz.div_start) begin
                start_cnt++;
                if (first_start < 0) first_start = w;
                else if (second_start < 0) second_start = w;
            end
        end
        check("b2b_start_count", 32'(start_cnt), 32'd2);
        check("b2b_start_gap", 32'(second_start - first_start), 32'd10);

        // Watchdog: divider never answers
        do_reset();
        @(negedge clk);
        hz.ex_is_div = 1'b1;
        #1;
        check("wd_start", 32'(hz.div_start), 32'd1);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd_k%0d", k),
                  32'({hz.div_error, hz.stall_pipeline, hz.div_start}),
                  32'({k >= 17, 1'b1, 1'b0}));
        end

        // Asynchronous reset three cycles into BUSY
        do_reset();
        @(negedge clk);
        hz.ex_is_div = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("arst_busy_stall", 32'(hz.stall_pipeline), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_outputs_zero", 32'(outs()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("arst_stall_cycles", hz.stall_cycles, 32'd0);
        check("arst_div_ops", 32'(hz.div_ops), 32'd0);
`endif
        @(negedge clk);
        hz.ex_is_div = 1'b0;
        rst          = 1'b1;
        #1;
        check("arst_release_idle", 32'(outs()), 32'd0);
        @(negedge clk);
        #1;
        check("arst_no_valid", 32'(outs()), 32'd0);
        @(negedge clk);
        hz.ex_is_div = 1'b1;
        #1;
        check("arst_restart", 32'({hz.div_start, hz.stall_pipeline}), 32'b11);

        // Randomized traffic against the reference model
        do_reset();
        want_div = 1'b0;
        lat      = 0;
        since    = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle_inputs();
            if (m_phase == 0) begin
                if (!want_div) want_div = ($urandom % 5 == 0);
                hz.ex_is_div = want_div;
                hz.div_done  = ($urandom % 8 == 0);
                if (want_div) begin
                    lat      = $urandom_range(1, 14);
                    since    = 0;
                    want_div = 1'b0;
                end
            end else if (m_phase == 1) begin
                since++;
                hz.ex_is_div = 1'b1;
                hz.div_done  = (since == lat);
            end else begin
                hz.ex_is_div = 1'b1;
                hz.div_done  = ($urandom % 4 == 0);
                want_div     = ($urandom % 3 == 0);
            end
            if (!hz.ex_is_div) begin
                hz.branch_taken = ($urandom % 6 == 0);
                hz.ex_is_load   = $urandom % 2;
            end
            hz.ex_rd       = 5'($urandom % 4);
            hz.id_rs1      = 5'($urandom % 4);
            hz.id_rs2      = 5'($urandom % 4);
            hz.id_uses_rs1 = $urandom % 2;
            hz.id_uses_rs2 = $urandom % 2;

            hz_m = hz.ex_is_load && hz.ex_rd != 0 &&
                   ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
                    (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
            br_m      = hz.branch_taken && !hz.ex_is_div && m_phase == 0;
            exp_start = (m_phase == 0) && hz.ex_is_div;
            exp_rv    = (m_phase == 2);
            exp_bub   = hz_m && !br_m;
            exp_stall = exp_start || (m_phase == 1) || exp_bub;
            #1;
            check("rand_outputs", 32'(outs()),
                  32'({exp_stall, exp_bub, br_m, br_m, exp_start, exp_rv, m_err}));
`ifdef HAZARD_PERF_CNT_EN
            check("rand_stall_cycles", hz.stall_cycles, m_stall_cycles);
            check("rand_div_ops", 32'(hz.div_ops), 32'(m_div_ops));
            m_stall_cycles += 32'(exp_stall);
            m_div_ops      += 16'(exp_start);
`endif
            case (m_phase)
                0: if (hz.ex_is_div) begin m_phase = 1; m_age = 0; end
                1: begin
                    if (hz.div_done) m_phase = 2;
                    else if (m_age == 15) m_err = 1'b1;
                    m_age++;
                end
                default: m_phase = 0;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Detects load-use hazards between ID and EX.
- Sequences the 8-cycle iterative divider in EX: start pulse, wait for done, watchdog.
- Produces the stall_pipeline and flush controls consumed by fetch, decode and the ID/EX register.
- Sits beside the datapath; its outputs gate PC update (stall_pipeline) and redirect (branch_taken passthrough priority).

Parameters:
DIV_LATENCY, 8, nominal divider cycles from div_start to div_done.
DIV_TIMEOUT, 16, busy cycles without div_done before div_error is set; must be > DIV_LATENCY.
CNT_W, 5, width of the busy-cycle counter; must hold DIV_TIMEOUT.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
id_rs1  in  5  source reg 1 of instruction in ID.
id_rs2  in  5  source reg 2 of instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  destination reg of instruction in EX.
ex_is_load  in  1  EX instruction is a load.
ex_is_div  in  1  EX instruction is DIV/DIVU/REM/REMU.
branch_taken  in  1  EX resolved a taken branch/jump.
div_done  in  1  divider result valid (1-cycle pulse).
stall_pipeline  out  1  hold PC and IF/ID, ID/EX.
bubble_de  out  1  load bubble into ID/EX while IF/ID holds.
flush_fd  out  1  squash IF/ID.
flush_de  out  1  squash ID/EX.
div_start  out  1  1-cycle divider launch.
div_result_valid  out  1  EX may write back divider result this cycle.
div_error  out  1  sticky watchdog flag.

Behaviour:
- rst low: state=IDLE, busy counter=0, div_error=0. All outputs are forced 0 while rst is low, regardless of inputs.
- States:
  - IDLE: ex_is_div=1 → div_start=1, stall_pipeline=1, go BUSY, counter=0.
  - BUSY: stall_pipeline=1, counter increments each cycle (saturates). div_done=1 → go DONE.
  - DONE: div_result_valid=1, stall_pipeline=0 (EX instruction advances), div_start=0 even though ex_is_div is still 1; next cycle → IDLE.
- Back-to-back divides: the second div reaches EX in the cycle after DONE, state is IDLE, and it launches immediately. No lost cycle beyond DONE.
- div_done while in IDLE or DONE is ignored.
- Watchdog: in BUSY with counter == DIV_TIMEOUT-1 and no div_done → div_error=1 (sticky until reset); the FSM stays BUSY.
- Load-use, combinational: hazard = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). hazard → stall_pipeline=1 and bubble_de=1 for exactly the cycle it holds; it clears the next cycle because the load has moved to MEM.
- Branch: branch_taken=1 → flush_fd=1, flush_de=1, and stall_pipeline=0 and bubble_de=0 in that cycle, so fetch loads branch_target. Branch overrides load-use.
- Branch and div cannot be in EX together; if both are asserted, div sequencing wins and branch_taken is ignored (flag as an assertion in verification).
- Reset asserted mid-BUSY: immediate return to IDLE, div_start=0, no div_result_valid. A divider still running after reset must be reset by the same rst.
- Only stall_pipeline, bubble_de, flush_*, div_start and div_result_valid are combinational from state+inputs. No combinational path from div_done to div_start.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, adds outputs stall_cycles[31:0] and div_ops[15:0].
- stall_cycles counts cycles with stall_pipeline=1.
- div_ops counts div_start pulses.
- Both wrap on overflow and clear on reset.
When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → stall_pipeline=1, bubble_de=1 for one cycle. Repeat with ex_rd=0 → no stall.
- Divide: ex_is_div=1 in IDLE, div_done 8 cycles after start → div_start pulses once, stall_pipeline=1 for 9 cycles, div_result_valid=1 in the next cycle, then IDLE.
- Back-to-back divides: two divs with div_done at 8 cycles each → two div_start pulses 10 cycles apart, no spurious third start during DONE.
- Branch vs load-use: branch_taken=1 and load-use hazard in the same cycle → flush_fd=flush_de=1, stall_pipeline=0, bubble_de=0.
- Watchdog: div started, div_done never arrives → div_error=1 exactly 16 busy cycles after entering BUSY; stays 1 and stall persists until rst low.
- Async reset mid-divide: drop rst 3 cycles into BUSY between clock edges → outputs 0 immediately; after release, IDLE with no div_result_valid. With HAZARD_PERF_CNT_EN defined, counters read 0.
